hamming_rx_assembler: RTL
=========================

# hamming_rx_assembler

Receive-side counterpart of the nibble encoding path: accepts Hamming(8,4) SECDED code bytes from the UART receive buffer, corrects single-bit errors, flags double-bit errors and reassembles nibble pairs into data bytes. It is the decoder for bytes produced by `encoding`. It runs in the `clk_4` domain between `UART_buffer` and `UART_transmitter`, and gates its output on the transmitter's `busy`.

## Interface
Parameters:
- TIMEOUT, 4096 — max cycles between first and second code byte of a pair before the partial pair is dropped.
- CNT_W, 8 — width of the saturating error counters.

Ports:
- clk  in  1  — single clock (`clk_4` domain).
- reset  in  1  — synchronous, active-high.
- active  in  1  — 1-cycle strobe; code_in valid.
- code_in  in  8  — SECDED code byte.
- busy  in  1  — downstream transmitter busy; output is held while high.
- byte_out  out  8  — assembled data byte; valid when ready=1.
- ready  out  1  — 1-cycle strobe; byte_out valid.
- err_fix  out  1  — with ready: at least one nibble of the byte was corrected.
- err_fatal  out  1  — with ready: at least one nibble was uncorrectable.
- drop  out  1  — 1-cycle pulse; partial pair discarded on timeout.
- overrun  out  1  — 1-cycle pulse; active arrived while in EMIT and the code byte was discarded.
- fix_cnt  out  CNT_W  — corrected-nibble count, saturating.
- fatal_cnt  out  CNT_W  — uncorrectable-nibble count, saturating.

## Operation
- Code format, data d[3:0], Hamming positions 1..7 map to c[0..6]:
  - c0=d0^d1^d3, c1=d0^d2^d3, c2=d0, c3=d1^d2^d3, c4=d1, c5=d2, c6=d3.
  - c7 = ^c[6:0], so the whole byte has even parity.
- Decode:
  - s1=c0^c2^c4^c6, s2=c1^c2^c5^c6, s4=c3^c4^c5^c6; s={s4,s2,s1}; p=^c[7:0].
  - s=0, p=0: clean.
  - p=1: single error. Flip c[s-1] when s≠0; s=0 means the error is in c7, data unaffected. Counts as fixed.
  - s≠0, p=0: double error, fatal. Nibble taken raw from c6,c5,c4,c2.
- Pairing: the first code byte of a pair is the low nibble, the second is the high nibble. byte_out={hi,lo}.
- FSM states:
  - LO: wait for first code byte. active → HI, timeout counter cleared.
  - HI: wait for second code byte. active → EMIT. Counter reaching TIMEOUT-1 with no active → drop pulse, → LO.
  - EMIT: when busy=0, pulse ready/err_fix/err_fatal, → LO. While busy=1, hold in EMIT with outputs stable.
- Overrun: active in EMIT raises an overrun pulse, the code byte is discarded, and state is unchanged.
- Counters:
  - Increment once per affected nibble, so +2 is possible per byte.
  - Saturate at 2^CNT_W−1; never wrap.
  - Cleared only by reset.

## Timing
- Reset values: all outputs 0, both counters 0, FSM in LO. Reset mid-pair or mid-EMIT discards the partial state; no ready follows.
- Pipeline: code_in is registered on active. Syndrome, correction and FSM update happen in the next cycle.
- Second active at cycle N with busy=0 → ready=1 at cycle N+2, exactly one cycle wide.
- busy high at N+2 → ready occurs in the first cycle busy is sampled low.
- err_fix/err_fatal are meaningful only while ready=1; they are 0 otherwise.
- An active in the same cycle as the timeout expiry counts as the second nibble; no drop.
- active is accepted in LO on the cycle immediately after a ready pulse. Back-to-back pairs give no gaps.

## Structure
- Shared package `hamming_pkg`:
  - codeword bit-position constants;
  - FSM state enum (LO, HI, EMIT);
  - pure function `secded_decode(code) → {nibble, fixed, fatal}`, so `decoding` and the bench reuse the same function.
- One natural sub-module: `secded_nibble_dec`, the registered single-codeword decoder. The top level contains the FSM, timeout counter and saturating counters.

## Test plan
- Clean pair: 0x2D then 0xD2, busy=0 → byte_out=0xA5, ready at N+2, err_fix=0, err_fatal=0.
- Single error: 0x29 (c2 flipped) then 0xD2 → 0xA5, err_fix=1, fix_cnt=1. Then 0xAD (c7 flipped) then 0xD2 → 0xA5, err_fix=1, fix_cnt=2.
- Double error: 0x2E then 0xD2 → ready with err_fatal=1, fatal_cnt=1, byte_out high nibble=0xA.
- Backpressure/overrun: busy=1 when second byte arrives → ready withheld; active during hold → overrun pulse. Release busy → single ready with 0xA5, then LO.
- Timeout: 0x2D, then idle for TIMEOUT cycles → drop pulse, no ready. Then 0x2D, 0xD2 → 0xA5.
- Reset/saturation:
  - Reset asserted while in HI → outputs and counters 0; the next pair decodes normally.
  - 300 single-error nibbles with CNT_W=8 → fix_cnt holds at 255.

Source files
------------

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared SECDED Hamming(8,4) types and decode function
// Purpose: codeword bit positions, assembler FSM state type, decode result
//          struct and the pure single-codeword decode function.
package hamming_pkg;

  // Data bit positions inside a code byte; c7 is overall parity.
  localparam int BIT_D0 = 2;
  localparam int BIT_D1 = 4;
  localparam int BIT_D2 = 5;
  localparam int BIT_D3 = 6;

  typedef enum logic [1:0] {
    ST_LO,
    ST_HI,
    ST_EMIT
  } state_t;

  typedef struct packed {
    logic [3:0] nibble;
    logic       fixed;
    logic       fatal;
  } dec_t;

  function automatic dec_t secded_decode(input logic [7:0] code);
    logic [7:0] c;
    logic [2:0] s;
    logic       p;
    dec_t       r;
    c    = code;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    p    = ^c;
    // Odd parity means one flipped bit; a zero syndrome puts it in c7,
    // which carries no data, so nothing needs flipping.
    if (p && (s != 3'd0)) begin
      c[s - 3'd1] = ~c[s - 3'd1];
    end
    r.fixed  = p;
    r.fatal  = !p && (s != 3'd0);
    r.nibble = {c[BIT_D3], c[BIT_D2], c[BIT_D1], c[BIT_D0]};
    return r;
  endfunction

endpackage

// File: rtl/hamming_rx_assembler_secded_nibble_dec.sv
// rtl/hamming_rx_assembler_secded_nibble_dec.sv - registered single-codeword SECDED decoder
// Purpose: capture a code byte on active and present its decode one cycle later.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   active, code_in - input strobe and code byte
//   valid           - decode of the captured byte is presented this cycle
//   dec             - {nibble, fixed, fatal} for the captured byte
module secded_nibble_dec
  import hamming_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic [7:0] code_in,
  output logic       valid,
  output dec_t       dec
);

  logic [7:0] code_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      code_q <= 8'd0;
    end else begin
      valid <= active;
      if (active) begin
        code_q <= code_in;
      end
    end
  end

  assign dec = secded_decode(code_q);

endmodule

// File: rtl/hamming_rx_assembler.sv
// rtl/hamming_rx_assembler.sv - SECDED nibble-pair receive assembler
// Purpose: decode pairs of Hamming(8,4) code bytes into data bytes, with
//          pair timeout, downstream busy hold and saturating error counters.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   active, code_in     - code byte strobe and value (low nibble first)
//   busy                - downstream busy; result held in EMIT while high
//   byte_out, ready     - assembled byte and its 1-cycle strobe
//   err_fix, err_fatal  - per-byte correction/uncorrectable flags with ready
//   drop                - partial pair discarded on timeout
//   overrun             - code byte discarded because a result was pending
//   fix_cnt, fatal_cnt  - saturating per-nibble error counts
module hamming_rx_assembler
  import hamming_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic [7:0]       code_in,
  input  logic             busy,
  output logic [7:0]       byte_out,
  output logic             ready,
  output logic             err_fix,
  output logic             err_fatal,
  output logic             drop,
  output logic             overrun,
  output logic [CNT_W-1:0] fix_cnt,
  output logic [CNT_W-1:0] fatal_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic          valid;
  dec_t          dec;
  logic          take_lo, take_hi;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    lo_nib, hi_nib;
  logic          lo_fix, lo_fatal;
  logic          pend_fix, pend_fatal;

  secded_nibble_dec u_dec (
    .clk     (clk),
    .reset   (reset),
    .active  (active),
    .code_in (code_in),
    .valid   (valid),
    .dec     (dec)
  );

  assign byte_out = {hi_nib, lo_nib};

  always_comb begin
    state_next = state;
    take_lo    = 1'b0;
    take_hi    = 1'b0;
    ready      = 1'b0;
    err_fix    = 1'b0;
    err_fatal  = 1'b0;
    drop       = 1'b0;
    overrun    = 1'b0;
    case (state)
      ST_LO: begin
        if (valid) begin
          take_lo    = 1'b1;
          state_next = ST_HI;
        end
      end
      ST_HI: begin
        // A byte arriving in the expiry cycle still completes the pair.
        if (valid) begin
          take_hi    = 1'b1;
          state_next = ST_EMIT;
        end else if (tmo_cnt == TMO_LAST) begin
          drop       = 1'b1;
          state_next = ST_LO;
        end
      end
      ST_EMIT: begin
        overrun = valid;
        if (!busy) begin
          ready      = 1'b1;
          err_fix    = pend_fix;
          err_fatal  = pend_fatal;
          state_next = ST_LO;
        end
      end
      default: state_next = ST_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_LO;
      tmo_cnt    <= '0;
      lo_nib     <= 4'd0;
      hi_nib     <= 4'd0;
      lo_fix     <= 1'b0;
      lo_fatal   <= 1'b0;
      pend_fix   <= 1'b0;
      pend_fatal <= 1'b0;
      fix_cnt    <= '0;
      fatal_cnt  <= '0;
    end else begin
      state <= state_next;
      if (take_lo) begin
        lo_nib   <= dec.nibble;
        lo_fix   <= dec.fixed;
        lo_fatal <= dec.fatal;
        tmo_cnt  <= '0;
      end else if (state == ST_HI) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (take_hi) begin
        hi_nib     <= dec.nibble;
        pend_fix   <= lo_fix | dec.fixed;
        pend_fatal <= lo_fatal | dec.fatal;
      end
      // Only nibbles accepted into a pair are counted; overrun bytes are not.
      if ((take_lo || take_hi) && dec.fixed && (fix_cnt != '1)) begin
        fix_cnt <= fix_cnt + 1'b1;
      end
      if ((take_lo || take_hi) && dec.fatal && (fatal_cnt != '1)) begin
        fatal_cnt <= fatal_cnt + 1'b1;
      end
    end
  end

endmodule
